// File: rtl/memory_bus_controller_if.sv
// Bus bundle between a CPU-side requester, the memory bus controller and its
// SRAM / IO targets.
//   CPU side : MemAddr, MemRead, MemWrite, LoadHalf, SaveHalf, MemWriteData -> controller
//              MemReadData, MemOK, bus_err <- controller
//   SRAM side: sram_en, sram_we, sram_addr, sram_wdata <- controller; sram_rdata -> controller
//   IO side  : io_req, io_we, io_addr, io_wdata <- controller; io_rdata, io_ack -> controller
// modport slave is the controller's view; modport master is the environment's view
// (CPU plus memory/IO responders).
interface memory_bus_controller_if;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic        LoadHalf;
  logic        SaveHalf;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        MemOK;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        io_req;
  logic        io_we;
  logic [13:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;

  logic        bus_err;

  modport slave (
    input  MemAddr, MemRead, MemWrite, LoadHalf, SaveHalf, MemWriteData,
    input  sram_rdata, io_rdata, io_ack,
    output MemReadData, MemOK, bus_err,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output io_req, io_we, io_addr, io_wdata
  );

  modport master (
    output MemAddr, MemRead, MemWrite, LoadHalf, SaveHalf, MemWriteData,
    output sram_rdata, io_rdata, io_ack,
    input  MemReadData, MemOK, bus_err,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  io_req, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/memory_bus_controller.sv
// Memory bus controller: turns CPU load/store requests into single-cycle SRAM
// accesses (addresses 0x0000_0000-0x0000_3FFF) or handshaked IO accesses
// (0x0000_4000-0x0000_7FFF). Anything else is unmapped and flags bus_err.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - memory_bus_controller_if.slave (CPU, SRAM and IO signals)
// Parameters:
//   IO_TIMEOUT - max IO_REQ cycles waiting for io_ack
//   ERR_DATA   - load data returned when an IO read times out
module memory_bus_controller #(
  parameter int unsigned IO_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input logic                    clk,
  input logic                    rst,
  memory_bus_controller_if.slave bus
);

  localparam int unsigned    CntW    = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(IO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StRamRd, StRamWait, StRamWr, StIoReq, StDone
  } state_t;

  state_t          state;
  logic            ignoreReq;  // swallow the strobe sampled right after DONE
  logic            isRead;
  logic            halfQ;
  logic            hiHalfQ;
  logic [CntW-1:0] timeoutCnt;

  logic            isRam;
  logic            isIo;
  logic [3:0]      wrMask;
  logic [31:0]     wrData;
  logic            unusedAddr;

  // Byte lane 0 select is meaningless on a 16/32-bit bus.
  assign unusedAddr = bus.MemAddr[0];

  always_comb begin
    isRam  = (bus.MemAddr[31:14] == 18'd0);
    isIo   = (bus.MemAddr[31:14] == 18'd1);
    wrData = bus.SaveHalf ? {2{bus.MemWriteData[15:0]}} : bus.MemWriteData;
    wrMask = !bus.SaveHalf ? 4'b1111 : (bus.MemAddr[1] ? 4'b1100 : 4'b0011);
  end

  function automatic logic [31:0] fmtLoad(input logic [31:0] word, input logic half,
                                          input logic hi);
    if (!half) return word;
    return hi ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      ignoreReq       <= 1'b0;
      isRead          <= 1'b0;
      halfQ           <= 1'b0;
      hiHalfQ         <= 1'b0;
      timeoutCnt      <= '0;
      bus.MemOK       <= 1'b0;
      bus.MemReadData <= '0;
      bus.bus_err     <= 1'b0;
      bus.sram_en     <= 1'b0;
      bus.sram_we     <= '0;
      bus.sram_addr   <= '0;
      bus.sram_wdata  <= '0;
      bus.io_req      <= 1'b0;
      bus.io_we       <= 1'b0;
      bus.io_addr     <= '0;
      bus.io_wdata    <= '0;
    end else begin
      bus.MemOK   <= 1'b0;
      bus.sram_en <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ignoreReq) begin
            ignoreReq <= 1'b0;
          end else if (bus.MemWrite || bus.MemRead) begin
            // Everything the access needs is latched here; later input changes are ignored.
            isRead  <= !bus.MemWrite;
            halfQ   <= bus.LoadHalf;
            hiHalfQ <= bus.MemAddr[1];
            if (isRam) begin
              bus.sram_en   <= 1'b1;
              bus.sram_addr <= bus.MemAddr[13:2];
              if (bus.MemWrite) begin
                bus.sram_we    <= wrMask;
                bus.sram_wdata <= wrData;
                state          <= StRamWr;
              end else begin
                bus.sram_we <= 4'b0000;
                state       <= StRamRd;
              end
            end else if (isIo) begin
              bus.io_req   <= 1'b1;
              bus.io_we    <= bus.MemWrite;
              bus.io_addr  <= bus.MemAddr[13:0];
              bus.io_wdata <= wrData;
              timeoutCnt   <= '0;
              state        <= StIoReq;
            end else begin
              if (!bus.MemWrite) bus.MemReadData <= '0;
              bus.bus_err <= 1'b1;
              bus.MemOK   <= 1'b1;
              state       <= StDone;
            end
          end
        end
        StRamRd: begin
          state <= StRamWait;
        end
        StRamWait: begin
          bus.MemReadData <= fmtLoad(bus.sram_rdata, halfQ, hiHalfQ);
          bus.MemOK       <= 1'b1;
          state           <= StDone;
        end
        StRamWr: begin
          bus.sram_we <= 4'b0000;
          bus.MemOK   <= 1'b1;
          state       <= StDone;
        end
        StIoReq: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.io_ack) begin
            if (isRead) bus.MemReadData <= fmtLoad(bus.io_rdata, halfQ, hiHalfQ);
            bus.io_req <= 1'b0;
            bus.io_we  <= 1'b0;
            bus.MemOK  <= 1'b1;
            state      <= StDone;
          end else if (timeoutCnt == CntLast) begin
            if (isRead) bus.MemReadData <= ERR_DATA;
            bus.bus_err <= 1'b1;
            bus.io_req  <= 1'b0;
            bus.io_we   <= 1'b0;
            bus.MemOK   <= 1'b1;
            state       <= StDone;
          end else begin
            timeoutCnt <= timeoutCnt + CntW'(1);
          end
        end
        StDone: begin
          ignoreReq <= 1'b1;
          state     <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench for memory_bus_controller: a vector table of single accesses
// (RAM word/half, IO with ack, IO timeout, unmapped) followed by hand-written
// sequences for held requests and reset in the middle of an IO access.
module tb_memory_bus_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_bus_controller_if bus ();

  memory_bus_controller #(
    .IO_TIMEOUT(8),
    .ERR_DATA  (32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM model: read data valid the cycle after sram_en with sram_we == 0.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we == 4'b0000) begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_we[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // IO responder: ack in the ackDelay-th cycle of io_req (0 = never).
  int          ackDelay = 0;
  int          ioCycles = 0;
  logic [31:0] ioRdata  = '0;
  always @(posedge clk) ioCycles <= bus.io_req ? ioCycles + 1 : 0;
  assign bus.io_ack   = bus.io_req && (ackDelay != 0) && (ioCycles == ackDelay - 1);
  assign bus.io_rdata = ioRdata;

  typedef struct packed {
    logic        wr;
    logic        half;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack;
    logic [31:0] ioRd;
    int          expLat;
    logic [31:0] expRd;
    logic [3:0]  expWe;
    logic [11:0] expSAddr;
    logic [13:0] expIoAddr;
    logic [31:0] expWdata;
    int          expSram;
    int          expIo;
    logic        expErr;
  } vec_t;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one access, hold strobes until MemOK, then leave the DUT idle and ready.
  task automatic runVec(input int idx, input vec_t v);
    int          lat;
    int          sramCyc;
    int          ioCyc;
    int          both;
    int          unstable;
    logic        done;
    logic [3:0]  we;
    logic [11:0] sa;
    logic [13:0] ia;
    logic [31:0] wd;
    string       p;
    p = $sformatf("v%0d", idx);
    lat = 0; sramCyc = 0; ioCyc = 0; both = 0; unstable = 0; done = 1'b0;
    we = '0; sa = '0; ia = '0; wd = '0;
    ackDelay         = v.ack;
    ioRdata          = v.ioRd;
    bus.MemAddr      = v.addr;
    bus.MemWriteData = v.wdata;
    bus.LoadHalf     = v.half & !v.wr;
    bus.SaveHalf     = v.half & v.wr;
    bus.MemWrite     = v.wr;
    bus.MemRead      = !v.wr;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        // Scramble everything but the strobes; the DUT must have latched them.
        bus.MemAddr      = ~v.addr;
        bus.MemWriteData = ~v.wdata;
        bus.LoadHalf     = ~bus.LoadHalf;
        bus.SaveHalf     = ~bus.SaveHalf;
      end
      if (bus.sram_en) begin
        sramCyc++;
        we = bus.sram_we; sa = bus.sram_addr; wd = bus.sram_wdata;
      end
      if (bus.io_req) begin
        if (ioCyc == 0) begin
          ia = bus.io_addr; we = {3'b000, bus.io_we}; wd = bus.io_wdata;
        end else if (bus.io_addr !== ia || bus.io_wdata !== wd) begin
          unstable++;
        end
        ioCyc++;
      end
      if (bus.sram_en && bus.io_req) both++;
      if (bus.MemOK) done = 1'b1;
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.LoadHalf = 1'b0; bus.SaveHalf = 1'b0;
    check({p, " MemOK seen"}, 32'(done), 32'd1);
    check({p, " latency"}, 32'(lat), 32'(v.expLat));
    check({p, " MemReadData"}, bus.MemReadData, v.expRd);
    check({p, " bus_err"}, 32'(bus.bus_err), 32'(v.expErr));
    check({p, " sram_en cycles"}, 32'(sramCyc), 32'(v.expSram));
    check({p, " io_req cycles"}, 32'(ioCyc), 32'(v.expIo));
    check({p, " sram/io overlap"}, 32'(both), 32'd0);
    if (v.expSram != 0) begin
      check({p, " sram_we"}, 32'(we), 32'(v.expWe));
      check({p, " sram_addr"}, 32'(sa), 32'(v.expSAddr));
    end
    if (v.expIo != 0) begin
      check({p, " io_we"}, 32'(we), 32'(v.expWe));
      check({p, " io_addr"}, 32'(ia), 32'(v.expIoAddr));
      check({p, " io held stable"}, 32'(unstable), 32'd0);
    end
    if (v.wr && (v.expSram + v.expIo) != 0) check({p, " write data"}, wd, v.expWdata);
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t vecs [20];
  vec_t hv;
  int   pulses;
  int   firstOk;
  int   secondOk;
  int   okSeen;

  initial begin
    // wr half addr wdata ack ioRd | lat rd we saddr ioaddr wdata nSram nIo err
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 0, 32'h0,
                 2, 32'h0000_0000, 4'hF, 12'h004, 14'h0000, 32'h1234_5678, 1, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0,
                 3, 32'h1234_5678, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1111_2222, 0, 32'h0,
                 2, 32'h1234_5678, 4'hF, 12'h004, 14'h0000, 32'h1111_2222, 1, 0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0012, 32'h0000_ABCD, 0, 32'h0,
                 2, 32'h1234_5678, 4'hC, 12'h004, 14'h0000, 32'hABCD_ABCD, 1, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0, 0, 32'h0,
                 3, 32'h0000_ABCD, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 32'h0,
                 3, 32'h0000_2222, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0,
                 3, 32'hABCD_2222, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0011, 32'h1234_5A5A, 0, 32'h0,
                 2, 32'hABCD_2222, 4'h3, 12'h004, 14'h0000, 32'h5A5A_5A5A, 1, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0,
                 3, 32'hABCD_5A5A, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 0, 32'h0,
                 2, 32'hABCD_5A5A, 4'hF, 12'hFFF, 14'h0000, 32'hCAFE_F00D, 1, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_3FFE, 32'h0, 0, 32'h0,
                 3, 32'hCAFE_F00D, 4'h0, 12'hFFF, 14'h0000, 32'h0, 1, 0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_4123, 32'h0, 5, 32'h0000_0055,
                 6, 32'h0000_0055, 4'h0, 12'h000, 14'h0123, 32'h0, 0, 5, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_7FFE, 32'h0000_0099, 5, 32'h0,
                 6, 32'h0000_0055, 4'h1, 12'h000, 14'h3FFE, 32'h0000_0099, 0, 5, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_4002, 32'h0, 1, 32'h1234_5678,
                 2, 32'h0000_1234, 4'h0, 12'h000, 14'h0002, 32'h0, 0, 1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_BEEF, 1, 32'h0,
                 2, 32'h0000_1234, 4'h1, 12'h000, 14'h0000, 32'hBEEF_BEEF, 0, 1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0000_5000, 32'h0, 8, 32'hA5A5_A5A5,
                 9, 32'hA5A5_A5A5, 4'h0, 12'h000, 14'h1000, 32'h0, 0, 8, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0, 0, 32'h0,
                 9, 32'hDEAD_BEEF, 4'h0, 12'h000, 14'h0000, 32'h0, 0, 8, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0,
                 3, 32'hABCD_5A5A, 4'h0, 12'h004, 14'h0000, 32'h0, 1, 0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 0, 32'h0,
                 1, 32'hABCD_5A5A, 4'h0, 12'h000, 14'h0000, 32'h0, 0, 0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 32'hFFFF_C000, 32'h0, 0, 32'h0,
                 1, 32'h0000_0000, 4'h0, 12'h000, 14'h0000, 32'h0, 0, 0, 1'b1};

    bus.MemAddr = '0; bus.MemWriteData = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.LoadHalf = 1'b0; bus.SaveHalf = 1'b0; bus.sram_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst MemOK", 32'(bus.MemOK), 32'd0);
    check("rst MemReadData", bus.MemReadData, 32'd0);
    check("rst sram_en", 32'(bus.sram_en), 32'd0);
    check("rst sram_we", 32'(bus.sram_we), 32'd0);
    check("rst io_req", 32'(bus.io_req), 32'd0);
    check("rst io_we", 32'(bus.io_we), 32'd0);
    check("rst bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0;

    // First request driven right at reset release: vecs[0] latency covers acceptance.
    for (int i = 0; i < 20; i++) runVec(i, vecs[i]);

    // Held read: strobe kept 4 cycles past MemOK must be serviced exactly twice.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("held pre bus_err", 32'(bus.bus_err), 32'd0);
    pulses = 0; firstOk = -1; secondOk = -1;
    bus.MemAddr = 32'h0000_0010; bus.MemRead = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.MemOK) begin
        pulses++;
        if (firstOk < 0) firstOk = i;
        else if (secondOk < 0) secondOk = i;
      end
      if (firstOk >= 0 && i == firstOk + 5) bus.MemRead = 1'b0;
    end
    bus.MemRead = 1'b0;
    check("held MemOK pulses", 32'(pulses), 32'd2);
    check("held first latency", 32'(firstOk), 32'd3);
    check("held pulse spacing", 32'(secondOk - firstOk), 32'd5);
    check("held MemReadData", bus.MemReadData, 32'hABCD_5A5A);

    // Unmapped read on a clean bus_err.
    hv = '{1'b0, 1'b0, 32'h0001_0000, 32'h0, 0, 32'h0,
           1, 32'h0000_0000, 4'h0, 12'h000, 14'h0000, 32'h0, 0, 0, 1'b1};
    runVec(20, hv);

    // Reset during IO_REQ: io_req drops at once, no MemOK, bus_err cleared.
    ackDelay = 0;
    bus.MemAddr = 32'h0000_4000; bus.MemRead = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort io_req active", 32'(bus.io_req), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort io_req dropped", 32'(bus.io_req), 32'd0);
    check("abort MemOK", 32'(bus.MemOK), 32'd0);
    check("abort bus_err", 32'(bus.bus_err), 32'd0);
    @(negedge clk); rst = 1'b0; bus.MemRead = 1'b0;
    okSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.MemOK) okSeen++;
    end
    check("abort no MemOK after", 32'(okSeen), 32'd0);
    check("abort bus_err after", 32'(bus.bus_err), 32'd0);

    // Request presented at reset release is taken on the first edge.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    runVec(21, vecs[10]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/memory_bus_controller.md
MEMORY_BUS_CONTROLLER -- requirements
Module: memory_bus_controller

Interface
REQ-001 Parameter IO_TIMEOUT, default 255: maximum cycles an IO transaction waits for io_ack.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on IO timeout.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 MemAddr  in  32  CPU byte address.
REQ-006 MemRead / MemWrite  in  1 each  CPU request strobes, held until MemOK.
REQ-007 LoadHalf / SaveHalf  in  1 each  16-bit access qualifiers.
REQ-008 MemWriteData  in  32  CPU store data.
REQ-009 MemReadData  out  32  registered load data to CPU.
REQ-010 MemOK  out  1  one-cycle completion pulse to CPU.
REQ-011 sram_en  out  1; sram_we  out  4 (byte enables); sram_addr  out  12 (word address); sram_wdata  out  32; sram_rdata  in  32 (valid one cycle after sram_en with sram_we=0).
REQ-012 io_req  out  1; io_we  out  1; io_addr  out  14; io_wdata  out  32; io_rdata  in  32; io_ack  in  1.
REQ-013 bus_err  out  1  sticky error flag.

Function
REQ-014 Address decode on MemAddr[31:14] as follows. 0: RAM, with sram_addr = MemAddr[13:2]. 1: IO, with io_addr = MemAddr[13:0]. Any other value: unmapped.
REQ-015 FSM states: IDLE, RAM_RD, RAM_WAIT, RAM_WR, IO_REQ, DONE.
REQ-016 IDLE: MemWrite=1 selects the write path; otherwise MemRead=1 selects the read path; both strobes high is treated as a write.
REQ-017 RAM read path: IDLE -> RAM_RD (sram_en=1, sram_we=0) -> RAM_WAIT (capture sram_rdata) -> DONE.
REQ-018 RAM write path: IDLE -> RAM_WR (sram_en=1, sram_we per REQ-021) -> DONE.
REQ-019 Read latency from request seen in IDLE to MemOK: exactly 3 cycles for RAM reads; exactly 2 cycles for RAM writes.
REQ-020 LoadHalf=1: MemReadData = {16'h0, word[31:16]} if MemAddr[1]=1, else {16'h0, word[15:0]}. LoadHalf=0: full word.
REQ-021 SaveHalf=1: sram_wdata = {MemWriteData[15:0], MemWriteData[15:0]}; sram_we = 4'b1100 if MemAddr[1]=1, else 4'b0011. SaveHalf=0: sram_we = 4'b1111.
REQ-022 MemAddr[0] is ignored; MemAddr[1:0] is ignored for word accesses.
REQ-023 IO path: IDLE -> IO_REQ. In IO_REQ, io_req=1 and io_we/io_addr/io_wdata are held stable until io_ack=1; the state then goes to DONE, capturing io_rdata on reads.
REQ-024 Half qualifiers apply to IO accesses exactly as in REQ-020/021; io_we is a single bit.
REQ-025 IO timeout: a cycle counter starts on entry to IO_REQ. After IO_TIMEOUT cycles without io_ack: go to DONE, set MemReadData = ERR_DATA on reads, set bus_err=1.
REQ-026 io_ack arriving on the same cycle the timeout expires counts as success.
REQ-027 Unmapped request: IDLE -> DONE directly. Reads return 32'h0, writes are discarded, bus_err=1, no sram/io strobe is issued.
REQ-028 DONE: MemOK=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-029 Strobes sampled in the cycle immediately after DONE are ignored, so a held request is never serviced twice. A request is accepted from the second cycle after MemOK.
REQ-030 MemReadData holds its value from MemOK until the next read completes; writes do not alter it.
REQ-031 sram_en and io_req are never asserted together; sram_en lasts exactly one cycle per access.
REQ-032 bus_err stays set until rst; a later successful access does not clear it.
REQ-033 Input changes during an in-flight access are ignored: address, data and qualifiers are latched when leaving IDLE.

Reset
REQ-034 rst=1 forces, asynchronously: FSM=IDLE; MemOK, sram_en, sram_we, io_req, io_we, bus_err = 0; MemReadData = 0; timeout counter = 0.
REQ-035 rst asserted mid-transaction abandons the access: io_req drops immediately and no MemOK is produced for the aborted request.
REQ-036 After rst deasserts, the first request is accepted on the first rising edge with rst=0.

Verification
REQ-037 RAM word write then read: write 0x12345678 to 0x0010, then read 0x0010. Required: sram_we=1111 and sram_addr=4 on the write; MemOK 2 cycles after the write request and 3 cycles after the read request; MemReadData=0x12345678.
REQ-038 Half access: SaveHalf write 0xABCD to 0x0012 over word 0x11112222, then LoadHalf read 0x0012 and 0x0010. Required: sram_we=1100; reads return 0x0000ABCD and 0x00002222.
REQ-039 IO read: io_ack given 5 cycles after io_req with io_rdata=0x55. Required: io_req held 5 cycles, io_addr=MemAddr[13:0], MemReadData=0x55, one MemOK pulse.
REQ-040 IO timeout: io_ack never asserted, IO_TIMEOUT=8. Required: MemOK after 8 IO_REQ cycles, MemReadData=0xDEADBEEF, bus_err=1 and still 1 after a later good access.
REQ-041 Held request and unmapped access: MemRead held 4 cycles past MemOK. Required: exactly 2 MemOK pulses, separated by the DONE and ignore cycles. Read of 0x00010000 returns 0 and sets bus_err with no sram/io strobe.
REQ-042 Reset mid-IO: rst pulsed during IO_REQ. Required: io_req=0 in the same cycle, no MemOK, bus_err=0.
